instr_exec_unit: RTL and testbench

//  Execution stage directly downstream of instr_register. On start, walks

---
 rtl/instr_exec_unit_if.sv | 59 +++++
 rtl/instr_exec_unit.sv | 150 +++++++++++++++
 tb/tb_instr_exec_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_exec_unit_if.sv
// Shared types and the bus interface for instr_exec_unit.
// Ports: master = execution unit side; slave = controller/register-file/consumer side.
// Carries run control, the instruction fetch path and the result valid/ready handshake.
package instr_exec_pkg;
   localparam int DEPTH = 32;
   localparam int OP_W  = 32;
   localparam int RES_W = 64;

   typedef logic [4:0]              address_t;
   typedef logic signed [OP_W-1:0]  operand_t;
   typedef logic signed [RES_W-1:0] result_t;

   typedef enum logic [2:0] {
      ZERO  = 3'd0,
      PASSA = 3'd1,
      PASSB = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      MULT  = 3'd5,
      DIV   = 3'd6,
      MOD   = 3'd7
   } opcode_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;
endpackage

interface instr_exec_unit_if;
   import instr_exec_pkg::*;

   // run control
   logic         start;
   address_t     start_ptr;
   logic [5:0]   num_instr;
   logic         busy;
   logic         done;
   // fetch path to instr_register (combinational read)
   address_t     read_pointer;
   instruction_t instruction_word;
   // result handshake
   result_t      result;
   opcode_t      result_opcode;
   logic         result_valid;
   logic         result_ready;
   logic         div_zero;

   modport master (
      input  start, start_ptr, num_instr, instruction_word, result_ready,
      output busy, done, read_pointer, result, result_opcode, result_valid, div_zero
   );

   modport slave (
      output start, start_ptr, num_instr, instruction_word, result_ready,
      input  busy, done, read_pointer, result, result_opcode, result_valid, div_zero
   );
endinterface

// File: rtl/instr_exec_unit.sv
// Execution stage: walks read_pointer over a window of instructions, executes each, emits results.
// Latency: 3 cycles from start to first result_valid; one result per 3 cycles with ready held high.
// Backpressure: OUT holds result/opcode/div_zero/valid and the pointer stable until valid&&ready.
// Ports: clk, reset_n (synchronous, active-low), bus (instr_exec_unit_if.master):
//   start/start_ptr/num_instr in, busy/done out, read_pointer out / instruction_word in,
//   result/result_opcode/div_zero/result_valid out, result_ready in.
module instr_exec_unit
   import instr_exec_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   instr_exec_unit_if.master  bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_OUT    = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]   state_q, state_d;
   address_t     rd_ptr_q, rd_ptr_d;
   logic [5:0]   remaining_q, remaining_d;
   instruction_t instr_q, instr_d;
   result_t      result_q, result_d;
   opcode_t      res_opc_q, res_opc_d;
   logic         res_vld_q, res_vld_d;
   logic         div_zero_q, div_zero_d;
   logic         done_q, done_d;

   result_t      a_ext, b_ext, b_safe, exec_res;
   logic         exec_dz;
   logic [5:0]   num_sat;

   // Arithmetic on the captured word. The divisor is forced non-zero so the
   // divider never sees zero; the b==0 case is overridden to result 0 anyway.
   always_comb begin
      a_ext    = {{(RES_W-OP_W){instr_q.op_a[OP_W-1]}}, instr_q.op_a};
      b_ext    = {{(RES_W-OP_W){instr_q.op_b[OP_W-1]}}, instr_q.op_b};
      b_safe   = (b_ext == '0) ? result_t'(1) : b_ext;
      exec_res = '0;
      exec_dz  = 1'b0;
      case (instr_q.opc)
         ZERO:  exec_res = '0;
         PASSA: exec_res = a_ext;
         PASSB: exec_res = b_ext;
         ADD:   exec_res = a_ext + b_ext;
         SUB:   exec_res = a_ext - b_ext;
         MULT:  exec_res = a_ext * b_ext;
         DIV: begin
            if (b_ext == '0) exec_dz  = 1'b1;
            else             exec_res = a_ext / b_safe;
         end
         MOD: begin
            if (b_ext == '0) exec_dz  = 1'b1;
            else             exec_res = a_ext % b_safe;
         end
         default: begin
            exec_res = '0;
            exec_dz  = 1'b0;
         end
      endcase
   end

   // Runs longer than the register file are clipped to one full pass.
   assign num_sat = (bus.num_instr > 6'(DEPTH)) ? 6'(DEPTH) : bus.num_instr;

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      remaining_d = remaining_q;
      instr_d     = instr_q;
      result_d    = result_q;
      res_opc_d   = res_opc_q;
      res_vld_d   = res_vld_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.num_instr != 6'd0) begin
                  state_d     = S_FETCH;
                  rd_ptr_d    = bus.start_ptr;
                  remaining_d = num_sat;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_FETCH: begin
            instr_d = bus.instruction_word;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            result_d   = exec_res;
            res_opc_d  = instr_q.opc;
            div_zero_d = exec_dz;
            res_vld_d  = 1'b1;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (bus.result_ready) begin
               res_vld_d   = 1'b0;
               remaining_d = remaining_q - 6'd1;
               rd_ptr_d    = rd_ptr_q + 5'd1;
               state_d     = (remaining_q > 6'd1) ? S_FETCH : S_FINISH;
            end
         end
         S_FINISH: begin
            // done is registered, so it appears the cycle we are back in IDLE.
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         remaining_q <= '0;
         instr_q     <= '0;
         result_q    <= '0;
         res_opc_q   <= ZERO;
         res_vld_q   <= 1'b0;
         div_zero_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         remaining_q <= remaining_d;
         instr_q     <= instr_d;
         result_q    <= result_d;
         res_opc_q   <= res_opc_d;
         res_vld_q   <= res_vld_d;
         div_zero_q  <= div_zero_d;
         done_q      <= done_d;
      end
   end

   assign bus.read_pointer  = rd_ptr_q;
   assign bus.result        = result_q;
   assign bus.result_opcode = res_opc_q;
   assign bus.result_valid  = res_vld_q;
   assign bus.div_zero      = div_zero_q;
   assign bus.done          = done_q;
   assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_exec_unit.sv
module tb_instr_exec_unit;
   import instr_exec_pkg::*;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_fail;

   instr_exec_unit_if bus ();

   instr_exec_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   instruction_t mem [32];
   assign bus.instruction_word = mem[bus.read_pointer];

   // results seen by the collector
   result_t  got_res [$];
   opcode_t  got_opc [$];
   logic     got_dz  [$];
   address_t got_ptr [$];
   int       got_cyc [$];
   int       done_cyc;
   logic     timed_out;

   function automatic instruction_t mk(opcode_t o, int a, int b);
      instruction_t w;
      w.opc  = o;
      w.op_a = a;
      w.op_b = b;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise start for one cycle; returns one step after the sampling edge (cycle 1).
   task automatic pulse_start(input address_t ptr, input logic [5:0] num);
      bus.start     = 1'b1;
      bus.start_ptr = ptr;
      bus.num_instr = num;
      step();
      bus.start     = 1'b0;
   endtask

   // Records every accepted result until done is seen or the budget runs out.
   task automatic collect(input int max_cyc);
      int c;
      got_res.delete(); got_opc.delete(); got_dz.delete();
      got_ptr.delete(); got_cyc.delete();
      timed_out = 1'b1;
      done_cyc  = -1;
      c = 1;
      for (int i = 0; i < max_cyc; i++) begin
         if (bus.result_valid && bus.result_ready) begin
            got_res.push_back(bus.result);
            got_opc.push_back(bus.result_opcode);
            got_dz.push_back(bus.div_zero);
            got_ptr.push_back(bus.read_pointer);
            got_cyc.push_back(c);
         end
         if (bus.done) begin
            timed_out = 1'b0;
            done_cyc  = c;
            break;
         end
         step();
         c++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      step();
      n_cmp++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.result_valid); end
      n_cmp++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
      n_cmp++; if (bus.result_opcode !== ZERO) begin n_fail++; $display("FAIL reset_opcode got=%0d exp=0", bus.result_opcode); end
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b done=%b dz=%b exp=000", bus.busy, bus.done, bus.div_zero); end
      n_cmp++; if (bus.read_pointer !== 5'd0) begin n_fail++; $display("FAIL reset_ptr got=%0d exp=0", bus.read_pointer); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      mem[0] = mk(ADD, 5, -7);
      bus.result_ready = 1'b1;
      pulse_start(5'd0, 6'd1);
      n_cmp++; if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_c1 busy=%b valid=%b exp busy=1 valid=0", bus.busy, bus.result_valid); end
      step();
      n_cmp++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_c2_valid got=%b exp=0", bus.result_valid); end
      step();
      n_cmp++; if (bus.result_valid !== 1'b1 || bus.result !== -64'sd2) begin n_fail++; $display("FAIL basic_c3 valid=%b result=%0d exp valid=1 result=-2", bus.result_valid, bus.result); end
      n_cmp++; if (bus.result_opcode !== ADD || bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL basic_c3_opc opc=%0d dz=%b exp opc=3 dz=0", bus.result_opcode, bus.div_zero); end
      step();
      n_cmp++; if (bus.result_valid !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_c4 valid=%b done=%b exp 0 0", bus.result_valid, bus.done); end
      step();
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_c5 done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy); end
      step();
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_c6_done_width got=%b exp=0", bus.done); end
   endtask

   task automatic test_ops();
      mem[4] = mk(MULT, -3, 40000);
      mem[5] = mk(DIV, -7, 2);
      mem[6] = mk(MOD, -7, 2);
      bus.result_ready = 1'b1;
      pulse_start(5'd4, 6'd3);
      collect(60);
      n_cmp++; if (timed_out !== 1'b0 || got_res.size() != 3) begin n_fail++; $display("FAIL ops_count timeout=%b results=%0d exp timeout=0 results=3", timed_out, got_res.size()); end
      if (got_res.size() == 3) begin
         n_cmp++; if (got_res[0] !== -64'sd120000) begin n_fail++; $display("FAIL ops_mult got=%0d exp=-120000", got_res[0]); end
         n_cmp++; if (got_res[1] !== -64'sd3) begin n_fail++; $display("FAIL ops_div got=%0d exp=-3", got_res[1]); end
         n_cmp++; if (got_res[2] !== -64'sd1) begin n_fail++; $display("FAIL ops_mod got=%0d exp=-1", got_res[2]); end
         n_cmp++; if (got_opc[0] !== MULT || got_opc[1] !== DIV || got_opc[2] !== MOD) begin n_fail++; $display("FAIL ops_opcodes got=%0d,%0d,%0d exp=5,6,7", got_opc[0], got_opc[1], got_opc[2]); end
         n_cmp++; if (got_cyc[0] != 3 || got_cyc[1] != 6 || got_cyc[2] != 9) begin n_fail++; $display("FAIL ops_timing got=%0d,%0d,%0d exp=3,6,9", got_cyc[0], got_cyc[1], got_cyc[2]); end
         n_cmp++; if (got_ptr[0] !== 5'd4 || got_ptr[2] !== 5'd6) begin n_fail++; $display("FAIL ops_ptr got=%0d..%0d exp=4..6", got_ptr[0], got_ptr[2]); end
      end
      step();
   endtask

   task automatic test_div_zero();
      mem[8]  = mk(DIV, 9, 0);
      mem[9]  = mk(ADD, 1, 2);
      mem[10] = mk(MOD, -5, 0);
      bus.result_ready = 1'b1;
      pulse_start(5'd8, 6'd3);
      collect(60);
      n_cmp++; if (timed_out !== 1'b0 || got_res.size() != 3) begin n_fail++; $display("FAIL dz_count timeout=%b results=%0d exp 0 3", timed_out, got_res.size()); end
      if (got_res.size() == 3) begin
         n_cmp++; if (got_res[0] !== '0 || got_dz[0] !== 1'b1) begin n_fail++; $display("FAIL dz_div res=%0d dz=%b exp res=0 dz=1", got_res[0], got_dz[0]); end
         n_cmp++; if (got_res[1] !== 64'sd3 || got_dz[1] !== 1'b0) begin n_fail++; $display("FAIL dz_clear res=%0d dz=%b exp res=3 dz=0", got_res[1], got_dz[1]); end
         n_cmp++; if (got_res[2] !== '0 || got_dz[2] !== 1'b1) begin n_fail++; $display("FAIL dz_mod res=%0d dz=%b exp res=0 dz=1", got_res[2], got_dz[2]); end
      end
      step();
   endtask

   task automatic test_backpressure();
      mem[12] = mk(SUB, 10, 3);
      mem[13] = mk(PASSB, 0, -9);
      bus.result_ready = 1'b0;
      pulse_start(5'd12, 6'd2);
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus.result_valid !== 1'b1 || bus.result !== 64'sd7 || bus.read_pointer !== 5'd12 || bus.result_opcode !== SUB) begin
            n_fail++;
            $display("FAIL bp_hold_%0d valid=%b res=%0d ptr=%0d opc=%0d exp 1 7 12 4", i, bus.result_valid, bus.result, bus.read_pointer, bus.result_opcode);
         end
         step();
      end
      bus.result_ready = 1'b1;
      step();
      n_cmp++; if (bus.result_valid !== 1'b0 || bus.read_pointer !== 5'd13) begin n_fail++; $display("FAIL bp_accept valid=%b ptr=%0d exp valid=0 ptr=13", bus.result_valid, bus.read_pointer); end
      collect(30);
      n_cmp++; if (timed_out !== 1'b0 || got_res.size() != 1) begin n_fail++; $display("FAIL bp_second_count timeout=%b results=%0d exp 0 1", timed_out, got_res.size()); end
      if (got_res.size() == 1) begin
         n_cmp++; if (got_res[0] !== -64'sd9) begin n_fail++; $display("FAIL bp_second got=%0d exp=-9", got_res[0]); end
      end
      step();
   endtask

   task automatic test_wrap_edge();
      mem[30] = mk(PASSB, 0, 77);
      mem[31] = mk(PASSA, 123, 0);
      mem[0]  = mk(MULT, -1, -1);
      mem[1]  = mk(ZERO, 5, 5);
      bus.result_ready = 1'b1;
      pulse_start(5'd31, 6'd2);
      n_cmp++; if (bus.read_pointer !== 5'd31) begin n_fail++; $display("FAIL wrap2_first_ptr got=%0d exp=31", bus.read_pointer); end
      collect(40);
      n_cmp++; if (got_res.size() != 2 || got_ptr[0] !== 5'd31 || got_ptr[1] !== 5'd0) begin n_fail++; $display("FAIL wrap2_ptrs n=%0d exp ptrs 31,0", got_res.size()); end
      step();
      pulse_start(5'd30, 6'd4);
      collect(60);
      n_cmp++;
      if (got_res.size() != 4) begin
         n_fail++; $display("FAIL wrap4_count got=%0d exp=4", got_res.size());
      end else if (got_ptr[0] !== 5'd30 || got_ptr[1] !== 5'd31 || got_ptr[2] !== 5'd0 || got_ptr[3] !== 5'd1) begin
         n_fail++; $display("FAIL wrap4_ptrs got=%0d,%0d,%0d,%0d exp=30,31,0,1", got_ptr[0], got_ptr[1], got_ptr[2], got_ptr[3]);
      end
      if (got_res.size() == 4) begin
         n_cmp++; if (got_res[0] !== 64'sd77 || got_res[1] !== 64'sd123 || got_res[2] !== 64'sd1 || got_res[3] !== 64'sd0) begin n_fail++; $display("FAIL wrap4_res got=%0d,%0d,%0d,%0d exp=77,123,1,0", got_res[0], got_res[1], got_res[2], got_res[3]); end
      end
      step();
      // empty run: FINISH immediately, no result
      pulse_start(5'd7, 6'd0);
      collect(10);
      n_cmp++; if (timed_out !== 1'b0 || done_cyc != 2 || got_res.size() != 0) begin n_fail++; $display("FAIL num0 timeout=%b done_cyc=%0d results=%0d exp 0 2 0", timed_out, done_cyc, got_res.size()); end
      step();
   endtask

   task automatic test_start_busy();
      int extra;
      mem[12] = mk(SUB, 10, 3);
      bus.result_ready = 1'b1;
      pulse_start(5'd12, 6'd1);
      bus.start     = 1'b1;
      bus.start_ptr = 5'd31;
      bus.num_instr = 6'd5;
      step();
      bus.start = 1'b0;
      collect(30);
      n_cmp++; if (timed_out !== 1'b0 || got_res.size() != 1) begin n_fail++; $display("FAIL busy_start_count timeout=%b results=%0d exp 0 1", timed_out, got_res.size()); end
      if (got_res.size() == 1) begin
         n_cmp++; if (got_res[0] !== 64'sd7 || got_ptr[0] !== 5'd12) begin n_fail++; $display("FAIL busy_start_res res=%0d ptr=%0d exp 7 12", got_res[0], got_ptr[0]); end
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.result_valid || bus.busy) extra++;
      end
      n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL busy_start_idle active_cycles=%0d exp=0", extra); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 32; i++) mem[i] = mk(PASSA, i, 0);
      bus.result_ready = 1'b1;
      pulse_start(5'd0, 6'd40);
      collect(200);
      n_cmp++; if (timed_out !== 1'b0 || got_res.size() != 32) begin n_fail++; $display("FAIL sat_count timeout=%b results=%0d exp 0 32", timed_out, got_res.size()); end
      if (got_res.size() == 32) begin
         n_cmp++; if (got_ptr[31] !== 5'd31 || got_res[31] !== 64'sd31) begin n_fail++; $display("FAIL sat_last ptr=%0d res=%0d exp 31 31", got_ptr[31], got_res[31]); end
      end
      step();
   endtask

   task automatic test_reset_midrun();
      int seen;
      mem[8] = mk(DIV, 9, 0);
      bus.result_ready = 1'b0;
      pulse_start(5'd8, 6'd2);
      step();
      step();
      n_cmp++; if (bus.result_valid !== 1'b1 || bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL rst_pre valid=%b dz=%b exp 1 1", bus.result_valid, bus.div_zero); end
      reset_n = 1'b0;
      step();
      n_cmp++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags valid=%b busy=%b done=%b dz=%b exp 0000", bus.result_valid, bus.busy, bus.done, bus.div_zero); end
      n_cmp++; if (bus.read_pointer !== 5'd0 || bus.result_opcode !== ZERO || bus.result !== '0) begin n_fail++; $display("FAIL rst_mid_bus ptr=%0d opc=%0d res=%0d exp 0 0 0", bus.read_pointer, bus.result_opcode, bus.result); end
      reset_n = 1'b1;
      bus.result_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.done || bus.result_valid) seen++;
      end
      n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_after done_or_valid_cycles=%0d exp=0", seen); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset_n          = 1'b0;
      bus.start        = 1'b0;
      bus.start_ptr    = '0;
      bus.num_instr    = '0;
      bus.result_ready = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      #1;
      test_reset();
      test_basic();
      test_ops();
      test_div_zero();
      test_backpressure();
      test_wrap_edge();
      test_start_busy();
      test_saturate();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
